// File: rtl/writeback_unit_if.sv
// Load-request and data-memory read bus between the pipeline, the writeback unit and memory.
// The master side issues loads and returns read data; the slave side is the writeback unit.
interface writeback_unit_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            ld_valid;
  logic            ld_ready;
  logic [RW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_funct3;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output ld_valid, ld_rd, ld_addr, ld_funct3, mem_rvalid, mem_rdata,
    input  ld_ready, mem_req, mem_addr
  );

  modport slave (
    input  ld_valid, ld_rd, ld_addr, ld_funct3, mem_rvalid, mem_rdata,
    output ld_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/writeback_unit.sv
// Final RV32 pipeline stage: merges ALU results with one outstanding load and drives
// the register file write port, aligning load data and squashing loads overtaken by the ALU.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            alu_valid,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_result,
  writeback_unit_if.slave bus,
  output logic [RW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            reg_we,
  output logic            busy,
  output logic [RW-1:0]   pending_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]      state;
  logic [1:0]      lane;
  logic [2:0]      funct3;
  logic [XLEN-1:0] load_buf;
  logic [XLEN-1:0] mem_addr_q;
  logic            squash;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] aligned;
  logic            alu_hit;

  assign busy         = (state != IDLE);
  assign bus.ld_ready = run && (state == IDLE);
  assign bus.mem_req  = run && (state == REQ);
  assign bus.mem_addr = mem_addr_q;
  assign alu_hit      = run && busy && alu_valid && (alu_rd == pending_rd) && (alu_rd != '0);

  always_comb begin
    lane_byte = bus.mem_rdata[7:0];
    case (lane)
      2'd1:    lane_byte = bus.mem_rdata[15:8];
      2'd2:    lane_byte = bus.mem_rdata[23:16];
      2'd3:    lane_byte = bus.mem_rdata[31:24];
      default: lane_byte = bus.mem_rdata[7:0];
    endcase
    lane_half = lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3)
      3'b000:  aligned = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b001:  aligned = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  aligned = {{(XLEN-8){1'b0}}, lane_byte};
      3'b101:  aligned = {{(XLEN-16){1'b0}}, lane_half};
      default: aligned = bus.mem_rdata;
    endcase
  end

  // The ALU owns the write slot whenever it is valid; a finished load only retires
  // on a cycle the ALU leaves free, and then writes unless it was squashed or targets r0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lane       <= '0;
      funct3     <= '0;
      load_buf   <= '0;
      mem_addr_q <= '0;
      squash     <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      reg_we     <= 1'b0;
      pending_rd <= '0;
    end else begin
      if (run && alu_valid) begin
        reg_we <= (alu_rd != '0);
        if (alu_rd != '0) begin
          waddr <= alu_rd;
          wdata <= alu_result;
        end
      end else if (run && state == WB) begin
        reg_we <= !squash && (pending_rd != '0);
        if (!squash && pending_rd != '0) begin
          waddr <= pending_rd;
          wdata <= load_buf;
        end
      end else begin
        reg_we <= 1'b0;
      end

      if (alu_hit) squash <= 1'b1;

      case (state)
        IDLE: begin
          if (run && bus.ld_valid) begin
            state      <= REQ;
            pending_rd <= bus.ld_rd;
            lane       <= bus.ld_addr[1:0];
            funct3     <= bus.ld_funct3;
            mem_addr_q <= {bus.ld_addr[XLEN-1:2], 2'b00};
            squash     <= 1'b0;
          end
        end
        REQ: begin
          if (run) state <= WAIT;
        end
        // Memory is never stalled, so returning data is taken even while frozen.
        WAIT: begin
          if (bus.mem_rvalid) begin
            load_buf <= aligned;
            state    <= WB;
          end
        end
        WB: begin
          if (run && !alu_valid) begin
            state      <= IDLE;
            pending_rd <= '0;
            squash     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the RV32 core. Drives the register file write port (waddr/wdata/reg_we).
- Merges single-cycle ALU results with multi-cycle loads.
- Sequences one outstanding data-memory read at a time.
- Aligns and sign-extends load data, and resolves write-port conflicts and WAW squashes.

Parameters:
- XLEN, 32, data/address width
- RW, 5, register index width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- run  input  1  global run enable; 0 freezes the block
- alu_valid  input  1  ALU result valid this cycle
- alu_rd  input  RW  ALU destination register
- alu_result  input  XLEN  ALU result
- ld_valid  input  1  load request valid
- ld_ready  output  1  load request accepted when ld_valid && ld_ready
- ld_rd  input  RW  load destination register
- ld_addr  input  XLEN  load byte address
- ld_funct3  input  3  RV32I load funct3
- mem_req  output  1  one-cycle read strobe
- mem_addr  output  XLEN  word-aligned read address
- mem_rvalid  input  1  read data valid
- mem_rdata  input  XLEN  read data word
- waddr  output  RW  register file write index
- wdata  output  XLEN  register file write data
- reg_we  output  1  register file write enable
- busy  output  1  load outstanding (state != IDLE)
- pending_rd  output  RW  destination of the outstanding load; 0 when idle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - mem_req, mem_addr, waddr, wdata, reg_we, pending_rd, and the load buffer all clear to 0.
- ld_ready = run && state==IDLE (combinational).
- FSM states and transitions:
  - IDLE -> REQ on accept. Latch ld_rd, ld_addr[1:0], ld_funct3; drive mem_addr={ld_addr[31:2],2'b00}.
  - REQ: mem_req=1 for exactly this cycle. Always -> WAIT.
  - WAIT: on mem_rvalid, capture the aligned result into the load buffer -> WB.
  - WB: waits for a free write slot -> IDLE when written (or squashed).
- mem_rvalid outside WAIT is ignored.
- Alignment, by funct3; byte lane = addr[1:0], half select = addr[1]:
  - LB 000: sign-extended byte.
  - LH 001: sign-extended half; addr[0] ignored.
  - LW 010: full word; addr[1:0] ignored.
  - LBU 100: zero-extended byte.
  - LHU 101: zero-extended half.
  - Any other funct3 is treated as LW.
- Write port: registered, one write per cycle. Decision in cycle C appears on the outputs in C+1.
  - If run && alu_valid: reg_we=1, waddr=alu_rd, wdata=alu_result.
  - Else if state==WB && !squash: reg_we=1, load result written, state -> IDLE.
  - Else: reg_we=0; waddr/wdata hold their previous values.
  - The ALU always has priority; a load result waits in WB indefinitely while ALU writes continue.
- Squash: if busy && alu_valid && alu_rd==pending_rd && alu_rd!=0 (while run=1), set a squash flag.
  - In WB the load then retires to IDLE without writing (reg_we=0 that cycle).
  - The memory read is still completed.
- rd=0: ALU or load with rd 0 still sequences normally but produces reg_we=0.
- Minimum load latency: accept at T, mem_req at T+1, rvalid at T+2, WB at T+3, reg_we=1 at T+4, ld_ready=1 at T+4.
- run=0:
  - FSM frozen, ld_ready=0, reg_we forced 0 the next cycle, mem_req deasserted.
  - A REQ state resumes its strobe when run returns.
  - mem_rvalid arriving in WAIT is still captured; memory is not stalled.
- Reset mid-load: any outstanding transaction is abandoned. A later stray mem_rvalid is ignored because the block is in IDLE.

Test Plan:
- Reset then alu_valid, alu_rd=5, alu_result=0xDEADBEEF for 1 cycle -> next cycle reg_we=1, waddr=5, wdata=0xDEADBEEF; the cycle after, reg_we=0.
- Load funct3=000, addr=0x103, rd=7; mem_rdata=0x80FF_1234 with rvalid 1 cycle after mem_req -> mem_addr=0x100, wdata=0xFFFFFF80 to r7 at T+4. Repeat with LHU at addr=0x102 -> wdata=0x000080FF.
- Load outstanding to rd=3 and ALU writes every cycle for 4 cycles while in WB -> load written the first cycle alu_valid=0; busy high until then.
- Load to rd=9 pending; ALU writes rd=9 value 0x11 before rvalid -> r9 written only with 0x11; load retires without reg_we; ld_ready returns high.
- run=0 asserted during WAIT with rvalid arriving -> data captured, no reg_we while run=0; write occurs 1 cycle after run=1.
- reset pulsed low in WAIT, then rvalid arrives -> all outputs 0, no write, ld_ready=1 once run=1.
